bias_fifo: RTL and testbench

//  Synchronous FIFO buffering bias words between the bias BRAM read controller and the core bias-add stage.

---
 rtl/bias_pkg.sv | 19 +
 rtl/bias_fifo_if.sv | 12 +
 rtl/bias_fifo_mem.sv | 18 +
 rtl/bias_fifo.sv | 72 +++++++
 tb/tb_bias_fifo.sv | 138 +++++++++++++
 5 files changed

// File: rtl/bias_pkg.sv
// bias_pkg: shared bias-path widths, depths and layer encoding.
package bias_pkg;
    localparam int BIAS_W          = 40;
    localparam int BIAS_MEM_DEPTH  = 49;
    localparam int LAYER_W         = 3;
    typedef enum logic [LAYER_W-1:0] {
        LAYER_IDLE = 3'd0,
        LAYER_1    = 3'd1,
        LAYER_2    = 3'd2,
        LAYER_3    = 3'd3,
        LAYER_4    = 3'd4,
        LAYER_5    = 3'd5,
        LAYER_6    = 3'd6,
        LAYER_DONE = 3'd7
    } layer_signal_t;
    localparam int BIAS_FIFO_DEPTH = 16;
    // BRAM read latency; the FIFO keeps this many slots free when it raises full
    localparam int BIAS_RD_LAT     = 2;
endpackage

// File: rtl/bias_fifo_if.sv
// bias_fifo_if: write/read/status bundle between bias BRAM controller, FIFO and core.
interface bias_fifo_if import bias_pkg::*; #(
    parameter int DATA_W = BIAS_W,
    parameter int DEPTH  = BIAS_FIFO_DEPTH
) ();
    localparam int ADDR_W = $clog2(DEPTH);
    logic              flush, wef, rd_en, full, dout_vld, empty, ovf, udf;
    logic [DATA_W-1:0] din, dout;
    logic [ADDR_W:0]   count;
    modport master (output flush, wef, din, rd_en, input full, dout, dout_vld, empty, count, ovf, udf);
    modport slave  (input flush, wef, din, rd_en, output full, dout, dout_vld, empty, count, ovf, udf);
endinterface

// File: rtl/bias_fifo_mem.sv
// bias_fifo_mem: unreset register array, one write port and one asynchronous read port.
module bias_fifo_mem import bias_pkg::*; #(
    parameter int   DATA_W = BIAS_W,
    parameter int   DEPTH  = BIAS_FIFO_DEPTH,
    localparam int  ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    always_ff @(posedge clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;
    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/bias_fifo.sv
// bias_fifo: bias-word FIFO with early full and sticky ovf/udf flags.
// BIAS_FIFO_FWFT_EN selects first-word fall-through output instead of a registered pop.
module bias_fifo import bias_pkg::*; #(
    parameter int  DATA_W    = BIAS_W,
    parameter int  DEPTH     = BIAS_FIFO_DEPTH,
    parameter int  AF_MARGIN = BIAS_RD_LAT,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input logic       clk,
    input logic       rst,
    bias_fifo_if.slave bus
);
    localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_AF  = (ADDR_W+1)'(DEPTH - AF_MARGIN);
    logic [ADDR_W:0]   r_wptr, r_rptr, r_count, w_cnt_nxt;
    logic              r_full, r_empty, r_ovf, r_udf, w_rd_acc, w_wr_acc;
    logic [DATA_W-1:0] w_rd_data;
    assign w_rd_acc  = bus.rd_en && !r_empty;
    // a pop in the same cycle frees the slot, so a full FIFO still takes the write
    assign w_wr_acc  = bus.wef && (r_count != CNT_MAX || w_rd_acc);
    assign w_cnt_nxt = r_count + (ADDR_W+1)'(w_wr_acc) - (ADDR_W+1)'(w_rd_acc);
    bias_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .i_we    (w_wr_acc && !bus.flush),
        .i_waddr (r_wptr[ADDR_W-1:0]),
        .i_wdata (bus.din),
        .i_raddr (r_rptr[ADDR_W-1:0]),
        .o_rdata (w_rd_data)
    );
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
            if (w_rd_acc) r_rptr <= r_rptr + 1'b1;
            r_count <= w_cnt_nxt;
            r_full  <= w_cnt_nxt >= CNT_AF;
            r_empty <= w_cnt_nxt == '0;
            if (bus.wef && !w_wr_acc) r_ovf <= 1'b1;
            if (bus.rd_en && r_empty) r_udf <= 1'b1;
        end
    end
    assign bus.count = r_count;
    assign bus.full  = r_full;
    assign bus.empty = r_empty;
    assign bus.ovf   = r_ovf;
    assign bus.udf   = r_udf;
`ifdef BIAS_FIFO_FWFT_EN
    assign bus.dout     = r_empty ? '0 : w_rd_data;
    assign bus.dout_vld = !r_empty;
`else
    logic [DATA_W-1:0] r_dout;
    logic              r_dout_vld;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout     <= '0;
            r_dout_vld <= 1'b0;
        end else begin
            r_dout_vld <= w_rd_acc && !bus.flush;
            if (w_rd_acc && !bus.flush) r_dout <= w_rd_data;
        end
    end
    assign bus.dout     = r_dout;
    assign bus.dout_vld = r_dout_vld;
`endif
endmodule

// File: tb/tb_bias_fifo.sv
// tb_bias_fifo: directed and random checks of bias_fifo against a queue model.
module tb_bias_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;
    logic [39:0] q [$];
    logic        m_ovf, m_udf, m_vld;
    logic [39:0] m_dout;

    bias_fifo_if #(.DATA_W(40), .DEPTH(16)) bus ();
    bias_fifo dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("count", 64'(bus.count), 64'(q.size()));
        chk("empty", 64'(bus.empty), 64'(q.size() == 0));
        chk("full",  64'(bus.full),  64'(q.size() >= 14));
        chk("ovf",   64'(bus.ovf),   64'(m_ovf));
        chk("udf",   64'(bus.udf),   64'(m_udf));
`ifdef BIAS_FIFO_FWFT_EN
        chk("dout_vld", 64'(bus.dout_vld), 64'(q.size() > 0));
        chk("dout",     64'(bus.dout),     64'(q.size() > 0 ? q[0] : 40'h0));
`else
        chk("dout_vld", 64'(bus.dout_vld), 64'(m_vld));
        chk("dout",     64'(bus.dout),     64'(m_dout));
`endif
    endtask

    // one clock of stimulus; the model applies the FIFO rules to the pre-edge occupancy
    task automatic cyc(input logic f, input logic w, input logic r, input logic [39:0] d);
        int sz;
        bit rd, wr;
        bus.flush = f;
        bus.wef   = w;
        bus.rd_en = r;
        bus.din   = d;
        sz = q.size();
        if (f) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            m_vld = 1'b0;
        end else begin
            rd = r && sz > 0;
            wr = w && (sz < 16 || rd);
            if (r && sz == 0) m_udf = 1'b1;
            if (w && !wr) m_ovf = 1'b1;
            m_vld = rd;
            if (rd) m_dout = q.pop_front();
            if (wr) q.push_back(d);
        end
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.wef   = 1'b0;
        bus.rd_en = 1'b0;
        check_all();
    endtask

    initial begin
        logic [39:0] d;
        bus.flush = 1'b0;
        bus.wef   = 1'b0;
        bus.rd_en = 1'b0;
        bus.din   = '0;
        repeat (2) @(posedge clk);
        #1;
        q.delete();
        m_ovf = 1'b0; m_udf = 1'b0; m_vld = 1'b0; m_dout = '0;
        check_all();
        rst = 1'b0;

        for (int i = 1; i <= 16; i++) cyc(1'b0, 1'b1, 1'b0, 40'(i));
        chk("t1_count16", 64'(bus.count), 64'd16);
        chk("t1_full", 64'(bus.full), 64'd1);
        cyc(1'b0, 1'b1, 1'b0, 40'h11);
        chk("t1_ovf", 64'(bus.ovf), 64'd1);

        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 1'b1, '0);
        chk("t2_empty", 64'(bus.empty), 64'd1);
        cyc(1'b0, 1'b0, 1'b1, '0);
        chk("t2_udf", 64'(bus.udf), 64'd1);

        cyc(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 1'b0, 40'(100 + i));
        cyc(1'b0, 1'b1, 1'b1, 40'hAA);
        chk("t3_count16", 64'(bus.count), 64'd16);
        chk("t3_ovf0", 64'(bus.ovf), 64'd0);
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 1'b1, '0);
`ifdef BIAS_FIFO_FWFT_EN
        chk("t3_last", 64'(bus.dout), 64'hAA);
        cyc(1'b0, 1'b0, 1'b1, '0);
`else
        cyc(1'b0, 1'b0, 1'b1, '0);
        chk("t3_last", 64'(bus.dout), 64'hAA);
`endif

        cyc(1'b0, 1'b1, 1'b1, 40'h5);
        chk("t4_udf", 64'(bus.udf), 64'd1);
        chk("t4_count1", 64'(bus.count), 64'd1);
        cyc(1'b0, 1'b0, 1'b1, '0);

        cyc(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 40'(200 + i));
        cyc(1'b1, 1'b1, 1'b0, 40'h99);
        chk("t5_count0", 64'(bus.count), 64'd0);
        cyc(1'b0, 1'b1, 1'b0, 40'h7);
        cyc(1'b0, 1'b0, 1'b1, '0);

        cyc(1'b1, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b1, 1'b0, 40'h0);
        for (int i = 1; i < 40; i++) cyc(1'b0, 1'b1, 1'b1, 40'(i));
        chk("t6_count1", 64'(bus.count), 64'd1);
        cyc(1'b0, 1'b0, 1'b1, '0);

        // random traffic: fill-heavy half, then drain-heavy half
        for (int i = 0; i < 400; i++) begin
            d = 40'({8'($urandom), $urandom});
            cyc($urandom_range(0, 49) == 0,
                i < 200 ? $urandom_range(0, 3) != 0 : $urandom_range(0, 3) == 0,
                i < 200 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 3) != 0,
                d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
